gpr_xfer_seq: RTL and testbench
===============================

GPR_XFER_SEQ -- requirements
Module: gpr_xfer_seq

Interface
REQ-001 Parameter: ALLOW_SWAP, default 1, enables the SWAP op; when 0, SWAP is rejected with err.
REQ-002 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 clear_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  1  request valid; sampled only while ready=1.
REQ-005 op  input  2  operation: 00 MOVE, 01 CLEAR, 10 SWAP, 11 LOAD.
REQ-006 ra  input  4  destination register index (first operand for SWAP).
REQ-007 rb  input  4  source register index (second operand for SWAP); ignored by CLEAR and LOAD.
REQ-008 stall  input  1  freezes the sequencer in its current state.
REQ-009 ready  output  1  high in IDLE only; req is accepted when req=1 and ready=1 at a clock edge.
REQ-010 done  output  1  one-cycle pulse in the final strobe cycle of each accepted op.
REQ-011 err  output  1  one-cycle pulse for a rejected request.
REQ-012 GRin  output  16  one-hot register write-enable vector to the general-purpose register file.
REQ-013 GRoutA  output  16  one-hot register read-select vector to the general-purpose register file.
REQ-014 reg_clear  output  1  forces the register-file clear value onto the write port.
REQ-015 TMPin, TMPout, EXTout  output  1 each  temp-register load, temp-register bus drive, and external-data bus drive.

Function
REQ-016 FSM states: IDLE, MOV, CLR, SW1, SW2, SW3, LD, ERR; all outputs are decoded from registered state and latched operands (Moore).
REQ-017 On acceptance: op, ra, and rb are latched; next state is MOV/CLR/SW1/LD per op; the req level outside IDLE is ignored.
REQ-018 MOV, 1 cycle: GRoutA=onehot(rb), GRin=onehot(ra), done=1; then IDLE.
REQ-019 CLR, 1 cycle: reg_clear=1, GRin=onehot(ra), GRoutA=0, done=1; then IDLE.
REQ-020 SW1: GRoutA=onehot(ra), TMPin=1. SW2: GRoutA=onehot(rb), GRin=onehot(ra). SW3: TMPout=1, GRin=onehot(rb), done=1; then IDLE.
REQ-021 LD, 1 cycle: EXTout=1, GRin=onehot(ra), done=1; then IDLE.
REQ-022 SWAP with ra==rb: goes directly to SW3 with GRin=0 and TMPout=0, done=1; no register is written.
REQ-023 SWAP with ALLOW_SWAP=0: enter ERR for 1 cycle with err=1, done=0, and all strobes 0; then IDLE.
REQ-024 MOVE with ra==rb is legal and executes normally.
REQ-025 stall=1 at an edge holds the state and latched operands; while stall=1, all strobes (GRin, GRoutA, reg_clear, TMPin, TMPout, EXTout) and done/err are forced to 0; ready stays 1 in IDLE, but no request is accepted while stall=1.
REQ-026 Latency from accepting edge to done: MOVE/CLEAR/LOAD 1 cycle, SWAP 3 cycles (1 if ra==rb), plus any stalled cycles.
REQ-027 ready=0 in every non-IDLE state; back-to-back ops are allowed: ready=1 in the cycle after done, and a new req may be accepted at that edge.
REQ-028 GRin and GRoutA each have at most one bit set in every cycle; all other strobes are 0 in IDLE.

Reset
REQ-029 clear_n=0 immediately forces IDLE and clears the latched operands; all outputs are 0 except ready=1.
REQ-030 Reset in mid-sequence (e.g. SW2) aborts with no further strobes; operation resumes from IDLE after clear_n rises.

Verification
REQ-031 MOVE ra=3, rb=7 -> next cycle GRoutA=16'h0080, GRin=16'h0008, done=1; following cycle ready=1.
REQ-032 SWAP ra=2, rb=5 -> SW1 GRoutA=16'h0004, TMPin=1; SW2 GRoutA=16'h0020, GRin=16'h0004; SW3 TMPout=1, GRin=16'h0020, done=1.
REQ-033 CLEAR ra=0 followed by LOAD ra=15 back-to-back -> reg_clear=1 with GRin=16'h0001; the next accepted op gives EXTout=1 with GRin=16'h8000.
REQ-034 SWAP with stall=1 held 2 cycles in SW2 -> all strobes 0 during the stall; done arrives 5 cycles after acceptance.
REQ-035 ALLOW_SWAP=0 with a SWAP request -> err pulse for 1 cycle, no strobes, ready=1 on the next cycle.
REQ-036 clear_n pulsed low during SW2 -> outputs drop asynchronously, ready=1, and no SW3 strobes ever appear.

Source files
------------

// File: rtl/gpr_xfer_seq.sv
// gpr_xfer_seq: sequences GPR-file strobes for MOVE, CLEAR, SWAP (via temp register) and LOAD.
// Outputs decode from registered state and latched operands, gated off while stalled.
module gpr_xfer_seq #(
    parameter bit ALLOW_SWAP = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_clear_n,
    input  logic        i_req,
    input  logic [1:0]  i_op,
    input  logic [3:0]  i_ra,
    input  logic [3:0]  i_rb,
    input  logic        i_stall,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_grin,
    output logic [15:0] o_grouta,
    output logic        o_reg_clear,
    output logic        o_tmpin,
    output logic        o_tmpout,
    output logic        o_extout
);
    typedef enum logic [2:0] {IDLE, MOV, CLR, SW1, SW2, SW3, LD, ERR} state_t;

    state_t      r_state;
    logic [3:0]  r_ra;
    logic [3:0]  r_rb;
    logic        r_same;
    logic        w_act;
    logic [15:0] w_oh_ra;
    logic [15:0] w_oh_rb;

    always_ff @(posedge i_clk or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state <= IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_same  <= 1'b0;
        end else if (!i_stall) begin
            case (r_state)
                IDLE: if (i_req) begin
                    r_ra   <= i_ra;
                    r_rb   <= i_rb;
                    r_same <= (i_ra == i_rb);
                    case (i_op)
                        2'b00:   r_state <= MOV;
                        2'b01:   r_state <= CLR;
                        // a self-swap is a no-op, so skip straight to the completing step
                        2'b10:   r_state <= !ALLOW_SWAP ? ERR : (i_ra == i_rb) ? SW3 : SW1;
                        default: r_state <= LD;
                    endcase
                end
                SW1:     r_state <= SW2;
                SW2:     r_state <= SW3;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        w_act       = !i_stall;
        w_oh_ra     = 16'd1 << r_ra;
        w_oh_rb     = 16'd1 << r_rb;
        o_ready     = (r_state == IDLE);
        o_done      = w_act && (r_state inside {MOV, CLR, SW3, LD});
        o_err       = w_act && (r_state == ERR);
        o_grin      = !w_act ? '0 : (r_state inside {MOV, CLR, SW2, LD}) ? w_oh_ra :
                      (r_state == SW3 && !r_same) ? w_oh_rb : '0;
        o_grouta    = !w_act ? '0 : (r_state inside {MOV, SW2}) ? w_oh_rb :
                      (r_state == SW1) ? w_oh_ra : '0;
        o_reg_clear = w_act && (r_state == CLR);
        o_tmpin     = w_act && (r_state == SW1);
        o_tmpout    = w_act && (r_state == SW3) && !r_same;
        o_extout    = w_act && (r_state == LD);
    end
endmodule

// File: tb/tb_gpr_xfer_seq.sv
// tb_gpr_xfer_seq: directed and random checks of gpr_xfer_seq (ALLOW_SWAP=1 and 0) against
// a per-operation list of expected output cycles.
module tb_gpr_xfer_seq;
    typedef struct packed {
        logic        ready;
        logic        done;
        logic        err;
        logic [15:0] grin;
        logic [15:0] grouta;
        logic        rclr;
        logic        tin;
        logic        tout;
        logic        ext;
    } obs_t;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       req = 1'b0;
    logic [1:0] op = '0;
    logic [3:0] ra = '0;
    logic [3:0] rb = '0;
    logic       stall = 1'b0;
    obs_t       o_a, o_n;
    obs_t       q_a[$];
    obs_t       q_n[$];
    int         checks = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    gpr_xfer_seq #(.ALLOW_SWAP(1'b1)) dut_a (
        .i_clk(clk), .i_clear_n(clear_n), .i_req(req), .i_op(op), .i_ra(ra), .i_rb(rb),
        .i_stall(stall), .o_ready(o_a.ready), .o_done(o_a.done), .o_err(o_a.err),
        .o_grin(o_a.grin), .o_grouta(o_a.grouta), .o_reg_clear(o_a.rclr),
        .o_tmpin(o_a.tin), .o_tmpout(o_a.tout), .o_extout(o_a.ext)
    );

    gpr_xfer_seq #(.ALLOW_SWAP(1'b0)) dut_n (
        .i_clk(clk), .i_clear_n(clear_n), .i_req(req), .i_op(op), .i_ra(ra), .i_rb(rb),
        .i_stall(stall), .o_ready(o_n.ready), .o_done(o_n.done), .o_err(o_n.err),
        .o_grin(o_n.grin), .o_grouta(o_n.grouta), .o_reg_clear(o_n.rclr),
        .o_tmpin(o_n.tin), .o_tmpout(o_n.tout), .o_extout(o_n.ext)
    );

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'h0001 << i;
    endfunction

    // Expected per-cycle outputs for one accepted operation, in order.
    task automatic push_op(input bit allow, input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        obs_t s[$];
        obs_t z;
        z = '0;
        case (o)
            2'd0: begin z.done = 1; z.grin = oh(a); z.grouta = oh(b); s.push_back(z); end
            2'd1: begin z.done = 1; z.grin = oh(a); z.rclr = 1; s.push_back(z); end
            2'd3: begin z.done = 1; z.grin = oh(a); z.ext = 1; s.push_back(z); end
            default: begin
                if (!allow) begin z.err = 1; s.push_back(z); end
                else if (a == b) begin z.done = 1; s.push_back(z); end
                else begin
                    z.grouta = oh(a); z.tin = 1; s.push_back(z);
                    z = '0; z.grouta = oh(b); z.grin = oh(a); s.push_back(z);
                    z = '0; z.grin = oh(b); z.tout = 1; z.done = 1; s.push_back(z);
                end
            end
        endcase
        foreach (s[i]) begin
            if (allow) q_a.push_back(s[i]);
            else q_n.push_back(s[i]);
        end
    endtask

    function automatic obs_t expect_of(input obs_t q[$]);
        obs_t r;
        r = '0;
        r.ready = (q.size() == 0);
        if (!stall && q.size() != 0) r = q[0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [38:0] obs, input logic [38:0] exp_v);
        checks++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a"}, o_a, expect_of(q_a));
        chk({tag, "_n"}, o_n, expect_of(q_n));
    endtask

    task automatic model_edge();
        if (!clear_n) begin
            q_a.delete();
            q_n.delete();
        end else if (!stall) begin
            if (q_a.size() != 0) void'(q_a.pop_front());
            else if (req) push_op(1'b1, op, ra, rb);
            if (q_n.size() != 0) void'(q_n.pop_front());
            else if (req) push_op(1'b0, op, ra, rb);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic [1:0] o, input logic [3:0] a,
                       input logic [3:0] b, input logic s);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        req = r; op = o; ra = a; rb = b; stall = s;
        #1;
        check_all(tag);
    endtask

    initial begin
        cyc("reset", 0, 0, 0, 0, 0);
        chk("reset_ready", 39'(o_a.ready), 39'(1));
        clear_n = 1'b1;
        // MOVE ra=3 rb=7
        cyc("mov_req", 1, 2'd0, 4'd3, 4'd7, 0);
        cyc("mov_ex", 0, 0, 0, 0, 0);
        chk("mov_grouta", 39'(o_a.grouta), 39'(16'h0080));
        chk("mov_grin", 39'(o_a.grin), 39'(16'h0008));
        chk("mov_done", 39'(o_a.done), 39'(1));
        cyc("mov_after", 0, 0, 0, 0, 0);
        chk("mov_ready", 39'(o_a.ready), 39'(1));
        // SWAP ra=2 rb=5; the no-swap instance must reject it
        cyc("sw_req", 1, 2'd2, 4'd2, 4'd5, 0);
        cyc("sw1", 0, 0, 0, 0, 0);
        chk("sw1_grouta", 39'(o_a.grouta), 39'(16'h0004));
        chk("sw1_tmpin", 39'(o_a.tin), 39'(1));
        chk("noswap_err", 39'(o_n.err), 39'(1));
        chk("noswap_strobes", 39'({o_n.grin, o_n.grouta, o_n.done}), 39'(0));
        cyc("sw2", 0, 0, 0, 0, 0);
        chk("sw2_grouta", 39'(o_a.grouta), 39'(16'h0020));
        chk("sw2_grin", 39'(o_a.grin), 39'(16'h0004));
        chk("noswap_ready", 39'(o_n.ready), 39'(1));
        cyc("sw3", 0, 0, 0, 0, 0);
        chk("sw3_grin", 39'(o_a.grin), 39'(16'h0020));
        chk("sw3_tout_done", 39'({o_a.tout, o_a.done}), 39'(3));
        // CLEAR ra=0 then LOAD ra=15 with req held high
        cyc("clr_req", 1, 2'd1, 4'd0, 4'd9, 0);
        cyc("clr_ex", 1, 2'd3, 4'd15, 4'd1, 0);
        chk("clr_grin", 39'({o_a.rclr, o_a.grin}), 39'({1'b1, 16'h0001}));
        cyc("ld_req", 1, 2'd3, 4'd15, 4'd1, 0);
        cyc("ld_ex", 0, 0, 0, 0, 0);
        chk("ld_grin", 39'({o_a.ext, o_a.grin}), 39'({1'b1, 16'h8000}));
        // SWAP stalled two cycles in SW2
        cyc("st_req", 1, 2'd2, 4'd2, 4'd5, 0);
        cyc("st_sw1", 0, 0, 0, 0, 0);
        cyc("st_sw2a", 0, 0, 0, 0, 1);
        chk("st_zero", 39'(o_a), 39'(0));
        cyc("st_sw2b", 0, 0, 0, 0, 1);
        cyc("st_sw2c", 0, 0, 0, 0, 0);
        cyc("st_sw3", 0, 0, 0, 0, 0);
        chk("st_done5", 39'(o_a.done), 39'(1));
        // self-swap and self-move
        cyc("ss_req", 1, 2'd2, 4'd4, 4'd4, 0);
        cyc("ss_ex", 0, 0, 0, 0, 0);
        chk("ss_done_nowrite", 39'({o_a.done, o_a.grin, o_a.tout}), 39'({1'b1, 16'h0, 1'b0}));
        cyc("sm_req", 1, 2'd0, 4'd6, 4'd6, 0);
        cyc("sm_ex", 0, 0, 0, 0, 0);
        // request during stall in IDLE is not accepted
        cyc("idle_stall", 1, 2'd0, 4'd1, 4'd2, 1);
        cyc("idle_after", 0, 0, 0, 0, 0);
        chk("idle_no_accept", 39'(o_a.ready), 39'(1));
        // asynchronous reset in SW2
        cyc("rs_req", 1, 2'd2, 4'd1, 4'd9, 0);
        cyc("rs_sw1", 0, 0, 0, 0, 0);
        cyc("rs_sw2", 0, 0, 0, 0, 0);
        #1 clear_n = 1'b0;
        #1;
        q_a.delete();
        q_n.delete();
        check_all("rs_async");
        cyc("rs_hold", 0, 0, 0, 0, 0);
        clear_n = 1'b1;
        cyc("rs_after1", 0, 0, 0, 0, 0);
        chk("rs_no_sw3", 39'({o_a.tout, o_a.grin, o_a.done}), 39'(0));
        cyc("rs_after2", 0, 0, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom_range(0, 15));
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom_range(0, 15));
            cyc("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, b,
                $urandom_range(0, 4) == 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
